game_sequencer: RTL and testbench

Sequencing controller for the pattern-memory game. It owns the read port of the 10-entry pattern memory and steps through the levels. For each level it plays back the first L entries to the display, then collects L player guesses and compares each one against memory. It also tracks lives, advances the level on success, and reports a 3-bit status in the same encoding as the existing `out` port.

---
 rtl/game_pkg.sv | 34 +++
 rtl/cycle_timer.sv | 33 +++
 rtl/game_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_game_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the pattern-memory game sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW,
        S_INPUT,
        S_WON,
        S_LOST
    } state_e;

    typedef enum logic [1:0] {
        PH_ADDR,
        PH_LATCH,
        PH_HOLD
    } show_ph_e;

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_OK   = 3'b010;
    localparam logic [2:0] ST_BAD  = 3'b001;
    localparam logic [2:0] ST_WON  = 3'b100;
    localparam logic [2:0] ST_LOST = 3'b011;

    localparam int DEF_DEPTH  = 10;
    localparam int DEF_DATA_W = 4;

    // Counter width able to hold the larger of two cycle limits.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/game_sequencer.sv
// Pattern-memory game sequencer: playback, guess checking, lives and levels.
// Optional per-guess timeout is built when GAME_TIMEOUT_EN is defined.
//
// state   | meaning
// S_IDLE  | after reset, waiting for start
// S_SHOW  | playing back entries 0..level-1 (ADDR, LATCH, HOLD per entry)
// S_INPUT | collecting guesses, mem_addr = guess index
// S_WON   | all levels cleared, waiting for start
// S_LOST  | out of lives, waiting for start
module game_sequencer
    import game_pkg::*;
#(
    parameter int DEPTH          = DEF_DEPTH,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int SHOW_CYCLES    = 50_000_000,
    parameter int LIVES          = 3,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       submit,
    input  logic [DATA_W-1:0]          data,
    output logic [$clog2(DEPTH)-1:0]   mem_addr,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       show_valid,
    output logic [DATA_W-1:0]          show_data,
    output logic [2:0]                 status,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [2:0]                 lives,
    output logic                       busy
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH + 1);
    // One width for both timers so the timeout limit always sizes something.
    localparam int TMR_W  = timer_width(SHOW_CYCLES, TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(SHOW_CYCLES - 1);

    state_e              state_q, state_d;
    show_ph_e            ph_q, ph_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [2:0]          lives_q, lives_d;
    logic [2:0]          status_q, status_d;
    logic [DATA_W-1:0]   show_data_q, show_data_d;
    logic                show_valid_q, show_valid_d;
    logic                rd_ok_q, rd_ok_d;

    logic                hold_load, hold_done;
    logic                accept, timeout;
    logic [ADDR_W-1:0]   last_idx;

    assign last_idx = ADDR_W'(level_q - 1'b1);
    assign accept   = (state_q == S_INPUT) && submit && rd_ok_q;

    cycle_timer #(.W(TMR_W)) u_hold_timer (
        .clk      (clk),
        .rst_n    (reset),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .done     (hold_done)
    );

`ifdef GAME_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TO_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    logic to_done;

    // Held loaded outside INPUT so counting starts on the entry edge.
    cycle_timer #(.W(TMR_W)) u_guess_timer (
        .clk      (clk),
        .rst_n    (reset),
        .load     ((state_q != S_INPUT) || accept),
        .load_val (TO_LOAD),
        .done     (to_done)
    );

    assign timeout = (state_q == S_INPUT) && to_done;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        addr_d       = addr_q;
        level_d      = level_q;
        lives_d      = lives_q;
        status_d     = status_q;
        show_data_d  = show_data_q;
        show_valid_d = show_valid_q;
        hold_load    = 1'b0;

        case (state_q)
            S_IDLE, S_WON, S_LOST: begin
                if (start) begin
                    state_d  = S_SHOW;
                    ph_d     = PH_ADDR;
                    addr_d   = '0;
                    level_d  = LVL_W'(1);
                    lives_d  = 3'(LIVES);
                    status_d = ST_IDLE;
                end
            end
            S_SHOW: begin
                case (ph_q)
                    PH_ADDR: ph_d = PH_LATCH;
                    PH_LATCH: begin
                        show_data_d  = mem_rdata;
                        show_valid_d = 1'b1;
                        hold_load    = 1'b1;
                        ph_d         = PH_HOLD;
                    end
                    PH_HOLD: begin
                        if (hold_done) begin
                            show_valid_d = 1'b0;
                            ph_d         = PH_ADDR;
                            if (addr_q == last_idx) begin
                                state_d = S_INPUT;
                                addr_d  = '0;
                            end else begin
                                addr_d = addr_q + 1'b1;
                            end
                        end
                    end
                    default: ph_d = PH_ADDR;
                endcase
            end
            S_INPUT: begin
                if (accept && (data == mem_rdata)) begin
                    status_d = ST_OK;
                    if (addr_q != last_idx) begin
                        addr_d = addr_q + 1'b1;
                    end else if (level_q != LVL_W'(DEPTH)) begin
                        level_d = level_q + 1'b1;
                        addr_d  = '0;
                        state_d = S_SHOW;
                        ph_d    = PH_ADDR;
                    end else begin
                        status_d = ST_WON;
                        state_d  = S_WON;
                    end
                end else if (accept || timeout) begin
                    if (lives_q > 3'd1) begin
                        lives_d  = lives_q - 1'b1;
                        status_d = ST_BAD;
                        addr_d   = '0;
                        state_d  = S_SHOW;
                        ph_d     = PH_ADDR;
                    end else begin
                        lives_d  = '0;
                        status_d = ST_LOST;
                        state_d  = S_LOST;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read data is stale for one cycle after the address moves.
    assign rd_ok_d = (state_q == S_INPUT) && (state_d == S_INPUT) && (addr_d == addr_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ph_q         <= PH_ADDR;
            addr_q       <= '0;
            level_q      <= '0;
            lives_q      <= 3'(LIVES);
            status_q     <= ST_IDLE;
            show_data_q  <= '0;
            show_valid_q <= 1'b0;
            rd_ok_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            addr_q       <= addr_d;
            level_q      <= level_d;
            lives_q      <= lives_d;
            status_q     <= status_d;
            show_data_q  <= show_data_d;
            show_valid_q <= show_valid_d;
            rd_ok_q      <= rd_ok_d;
        end
    end

    assign mem_addr   = addr_q;
    assign show_valid = show_valid_q;
    assign show_data  = show_data_q;
    assign status     = status_q;
    assign level      = level_q;
    assign lives      = lives_q;
    assign busy       = (state_q == S_SHOW) || (state_q == S_INPUT);

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: table-driven first level plus hand sequences.
module tb_game_sequencer;

    localparam int DEPTH  = 10;
    localparam int DATA_W = 4;
    localparam int SC     = 4;
    localparam int LIVES  = 3;
    localparam int TO     = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              submit;
    logic [DATA_W-1:0] data;
    logic [3:0]        mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              show_valid;
    logic [DATA_W-1:0] show_data;
    logic [2:0]        status;
    logic [3:0]        level;
    logic [2:0]        lives;
    logic              busy;

    logic [DATA_W-1:0] mem [16];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) mem_rdata <= mem[mem_addr];

    game_sequencer #(
        .DEPTH          (DEPTH),
        .DATA_W         (DATA_W),
        .SHOW_CYCLES    (SC),
        .LIVES          (LIVES),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .submit     (submit),
        .data       (data),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .show_valid (show_valid),
        .show_data  (show_data),
        .status     (status),
        .level      (level),
        .lives      (lives),
        .busy       (busy)
    );

    typedef struct {
        logic       start;
        logic       submit;
        logic [3:0] data;
        logic [2:0] st;
        logic [3:0] lvl;
        logic [2:0] lv;
        logic       bsy;
        logic       sv;
        logic [3:0] sd;
        logic [3:0] addr;
    } vec_t;

    vec_t vec [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic [3:0] lvl,
                             input logic [2:0] lv, input logic bsy);
        check({tag, " status"}, 32'(status), 32'(st));
        check({tag, " level"},  32'(level),  32'(lvl));
        check({tag, " lives"},  32'(lives),  32'(lv));
        check({tag, " busy"},   32'(busy),   32'(bsy));
    endtask

    // Called one step after SHOW entry; returns one step after INPUT entry.
    task automatic check_show(input int lvl);
        int n;
        int loc;
        for (int t = 0; t < lvl * (SC + 2); t++) begin
            n   = t / (SC + 2);
            loc = t % (SC + 2);
            check($sformatf("L%0d t%0d show_valid", lvl, t), 32'(show_valid), 32'(loc >= 2));
            if (loc == 0)
                check($sformatf("L%0d t%0d mem_addr", lvl, t), 32'(mem_addr), 32'(n));
            if (loc == 2)
                check($sformatf("L%0d t%0d show_data", lvl, t), 32'(show_data), 32'(mem[n]));
            tick();
        end
        check($sformatf("L%0d input busy", lvl), 32'(busy), 32'(1));
        check($sformatf("L%0d input mem_addr", lvl), 32'(mem_addr), 32'(0));
    endtask

    task automatic guess(input logic [3:0] d);
        tick();
        data   = d;
        submit = 1'b1;
        tick();
        submit = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " mem_addr"},   32'(mem_addr),   32'(0));
        check({tag, " show_valid"}, 32'(show_valid), 32'(0));
        check({tag, " show_data"},  32'(show_data),  32'(0));
        check_all(tag, 3'b000, 4'd0, 3'd3, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'(i);
        reset  = 1'b0;
        start  = 1'b0;
        submit = 1'b0;
        data   = '0;
        repeat (3) tick();
        check_reset_vals("reset");
        reset = 1'b1;

        // Level 1 cycle by cycle: start+submit together, dropped stale submit, accept.
        vec[0] = '{1'b1, 1'b1, 4'd0, 3'b000, 4'd1, 3'd3, 1'b1, 1'b0, 4'd0, 4'd0};
        vec[1] = '{1'b0, 1'b0, 4'd0, 3'b000, 4'd1, 3'd3, 1'b1, 1'b0, 4'd0, 4'd0};
        vec[2] = '{1'b0, 1'b0, 4'd0, 3'b000, 4'd1, 3'd3, 1'b1, 1'b1, 4'd0, 4'd0};
        vec[3] = '{1'b0, 1'b0, 4'd0, 3'b000, 4'd1, 3'd3, 1'b1, 1'b1, 4'd0, 4'd0};
        vec[4] = '{1'b0, 1'b0, 4'd0, 3'b000, 4'd1, 3'd3, 1'b1, 1'b1, 4'd0, 4'd0};
        vec[5] = '{1'b0, 1'b0, 4'd0, 3'b000, 4'd1, 3'd3, 1'b1, 1'b1, 4'd0, 4'd0};
        vec[6] = '{1'b0, 1'b0, 4'd0, 3'b000, 4'd1, 3'd3, 1'b1, 1'b0, 4'd0, 4'd0};
        vec[7] = '{1'b0, 1'b1, 4'd5, 3'b000, 4'd1, 3'd3, 1'b1, 1'b0, 4'd0, 4'd0};
        vec[8] = '{1'b0, 1'b1, 4'd0, 3'b010, 4'd2, 3'd3, 1'b1, 1'b0, 4'd0, 4'd0};
        for (int r = 0; r < 9; r++) begin
            start  = vec[r].start;
            submit = vec[r].submit;
            data   = vec[r].data;
            tick();
            check_all($sformatf("row%0d", r), vec[r].st, vec[r].lvl, vec[r].lv, vec[r].bsy);
            check($sformatf("row%0d show_valid", r), 32'(show_valid), 32'(vec[r].sv));
            check($sformatf("row%0d show_data", r),  32'(show_data),  32'(vec[r].sd));
            check($sformatf("row%0d mem_addr", r),   32'(mem_addr),   32'(vec[r].addr));
        end
        start  = 1'b0;
        submit = 1'b0;

        // Level 2 -> 3, then start ignored in INPUT.
        check_show(2);
        guess(4'd0);
        check_all("L2 g0", 3'b010, 4'd2, 3'd3, 1'b1);
        check("L2 g0 mem_addr", 32'(mem_addr), 32'(1));
        guess(4'd1);
        check_all("L2 g1", 3'b010, 4'd3, 3'd3, 1'b1);
        check_show(3);
        pulse_start();
        check_all("start in INPUT", 3'b010, 4'd3, 3'd3, 1'b1);
        check("start in INPUT show_valid", 32'(show_valid), 32'(0));

        // Wrong guesses: replay at same level, then LOST.
        guess(4'd5);
        check_all("wrong1", 3'b001, 4'd3, 3'd2, 1'b1);
        check_show(3);
        guess(4'd0);
        check_all("retry g0", 3'b010, 4'd3, 3'd2, 1'b1);
        guess(4'd7);
        check_all("wrong2", 3'b001, 4'd3, 3'd1, 1'b1);
        check("wrong2 mem_addr", 32'(mem_addr), 32'(0));
        check_show(3);
        guess(4'd9);
        check_all("lost", 3'b011, 4'd3, 3'd0, 1'b0);
        repeat (2) tick();
        check_all("lost hold", 3'b011, 4'd3, 3'd0, 1'b0);
        pulse_start();
        check_all("start from LOST", 3'b000, 4'd1, 3'd3, 1'b1);

        // Full correct run to WON.
        for (int lvl = 1; lvl <= DEPTH; lvl++) begin
            check_show(lvl);
            for (int i = 0; i < lvl; i++) begin
                guess(mem[i]);
                if (i < lvl - 1)
                    check_all($sformatf("run L%0d g%0d", lvl, i), 3'b010, 4'(lvl), 3'd3, 1'b1);
                else if (lvl < DEPTH)
                    check_all($sformatf("run L%0d g%0d", lvl, i), 3'b010, 4'(lvl + 1), 3'd3, 1'b1);
                else
                    check_all($sformatf("run L%0d g%0d", lvl, i), 3'b100, 4'd10, 3'd3, 1'b0);
            end
        end
        repeat (2) tick();
        check_all("won hold", 3'b100, 4'd10, 3'd3, 1'b0);
        pulse_start();
        check_all("start from WON", 3'b000, 4'd1, 3'd3, 1'b1);

        // Async reset in the middle of level-2 playback.
        check_show(1);
        guess(4'd0);
        check_all("pre-reset", 3'b010, 4'd2, 3'd3, 1'b1);
        repeat (8) tick();
        check("pre-reset show_valid", 32'(show_valid), 32'(1));
        check("pre-reset show_data",  32'(show_data),  32'(1));
        check("pre-reset mem_addr",   32'(mem_addr),   32'(1));
        reset = 1'b0;
        #1;
        check_reset_vals("async reset");
        tick();
        reset = 1'b1;

`ifdef GAME_TIMEOUT_EN
        pulse_start();
        check_show(1);
        repeat (TO - 1) tick();
        check_all("timeout before", 3'b000, 4'd1, 3'd3, 1'b1);
        tick();
        check_all("timeout fired", 3'b001, 4'd1, 3'd2, 1'b1);
        check_show(1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
